// File: rtl/stg4mo_pkg.sv
// Shared widths, timeout default and state encoding for the
// memory-operation stage.
package stg4mo_pkg;

    localparam int SIZE_ADDR   = 24;
    localparam int SIZE_DATA   = 24;
    localparam int SIZE_TGT_GP = 4;
    localparam int SIZE_TMO    = 15;

    typedef enum logic {
        MO_IDLE = 1'b0,
        MO_WAIT = 1'b1
    } mo_state_e;

endpackage

// File: rtl/stg4mo_tmo.sv
// Loadable down-counter with clear; expired_o flags a zero count.
// Reusable as a bus-access watchdog.
module stg4mo_tmo #(
    parameter int W    = 4,
    parameter int INIT = 14
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = W'(INIT);
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/stg4mo.sv
// Memory-operation pipeline stage: issues loads/stores on a
// req/ack port, stalls upstream while waiting, feeds writeback.
module stg4mo
    import stg4mo_pkg::*;
#(
    parameter int ADDR_W  = SIZE_ADDR,
    parameter int DATA_W  = SIZE_DATA,
    parameter int TGT_W   = SIZE_TGT_GP,
    parameter int TMO_CYC = SIZE_TMO
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_valid,
    input  logic [ADDR_W-1:0] iw_pc,
    input  logic [DATA_W-1:0] iw_instr,
    input  logic [DATA_W-1:0] iw_result,
    input  logic              iw_wb_en,
    input  logic [TGT_W-1:0]  iw_tgt_gp,
    input  logic              iw_mem_rd,
    input  logic              iw_mem_wr,
    input  logic [ADDR_W-1:0] iw_mem_addr,
    input  logic [DATA_W-1:0] iw_mem_wdata,
    output logic              ow_stall,
    output logic              ow_mem_req,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic              iw_mem_ack,
    input  logic [DATA_W-1:0] iw_mem_rdata,
    output logic              ow_valid,
    output logic [ADDR_W-1:0] ow_pc,
    output logic [DATA_W-1:0] ow_instr,
    output logic              ow_wb_en,
    output logic [TGT_W-1:0]  ow_tgt_gp,
    output logic [DATA_W-1:0] ow_wb_data,
    output logic              ow_bus_err
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    mo_state_e   state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] cpc_q, cpc_d;
    logic [DATA_W-1:0] cins_q, cins_d;
    logic [TGT_W-1:0]  ctgt_q, ctgt_d;
    logic        valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic        wb_en_q, wb_en_d;
    logic [TGT_W-1:0]  tgt_q, tgt_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic        berr_q, berr_d;

    logic tmo_load, tmo_dec, tmo_clr;
    logic tmo_exp;

    stg4mo_tmo #(
        .W    (TMO_W),
        .INIT (TMO_CYC - 1)
    ) u_tmo (
        .clk_i     (iw_clk),
        .rst_i     (iw_rst),
        .load_i    (tmo_load),
        .dec_i     (tmo_dec),
        .clr_i     (tmo_clr),
        .expired_o (tmo_exp)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cpc_d     = cpc_q;
        cins_d    = cins_q;
        ctgt_d    = ctgt_q;
        valid_d   = 1'b0;
        pc_d      = pc_q;
        instr_d   = instr_q;
        wb_en_d   = wb_en_q;
        tgt_d     = tgt_q;
        wb_data_d = wb_data_q;
        berr_d    = 1'b0;
        tmo_load  = 1'b0;
        tmo_dec   = 1'b0;
        tmo_clr   = 1'b0;
        unique case (state_q)
            MO_IDLE: begin
                if (iw_valid && (iw_mem_rd || iw_mem_wr)) begin
                    state_d  = MO_WAIT;
                    req_d    = 1'b1;
                    we_d     = iw_mem_wr;
                    addr_d   = iw_mem_addr;
                    wdata_d  = iw_mem_wdata;
                    cpc_d    = iw_pc;
                    cins_d   = iw_instr;
                    ctgt_d   = iw_tgt_gp;
                    tmo_load = 1'b1;
                end else if (iw_valid) begin
                    valid_d   = 1'b1;
                    pc_d      = iw_pc;
                    instr_d   = iw_instr;
                    tgt_d     = iw_tgt_gp;
                    wb_en_d   = iw_wb_en;
                    wb_data_d = iw_result;
                end
            end
            MO_WAIT: begin
                if (iw_mem_ack || tmo_exp) begin
                    state_d = MO_IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    pc_d    = cpc_q;
                    instr_d = cins_q;
                    tgt_d   = ctgt_q;
                    tmo_clr = 1'b1;
                end else begin
                    tmo_dec = 1'b1;
                end
                // Ack beats the watchdog when both land together.
                if (iw_mem_ack) begin
                    wb_en_d   = ~we_q;
                    wb_data_d = we_q ? '0 : iw_mem_rdata;
                end else if (tmo_exp) begin
                    berr_d    = 1'b1;
                    wb_en_d   = 1'b0;
                    wb_data_d = '0;
                end
            end
            default: state_d = MO_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q   <= MO_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpc_q     <= '0;
            cins_q    <= '0;
            ctgt_q    <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            wb_en_q   <= 1'b0;
            tgt_q     <= '0;
            wb_data_q <= '0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpc_q     <= cpc_d;
            cins_q    <= cins_d;
            ctgt_q    <= ctgt_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            wb_en_q   <= wb_en_d;
            tgt_q     <= tgt_d;
            wb_data_q <= wb_data_d;
            berr_q    <= berr_d;
        end
    end

    assign ow_stall     = (state_q == MO_WAIT);
    assign ow_mem_req   = req_q;
    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = wdata_q;
    assign ow_valid     = valid_q;
    assign ow_pc        = pc_q;
    assign ow_instr     = instr_q;
    assign ow_wb_en     = wb_en_q;
    assign ow_tgt_gp    = tgt_q;
    assign ow_wb_data   = wb_data_q;
    assign ow_bus_err   = berr_q;

endmodule

// File: tb/tb_stg4mo.sv
// Directed bench for stg4mo: ALU pass-through, load/store,
// watchdog abort, ack-vs-timeout race and reset mid-access.
module tb_stg4mo;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [23:0] pc;
    logic [23:0] instr;
    logic [23:0] result;
    logic        wb_en;
    logic [3:0]  tgt;
    logic        mem_rd;
    logic        mem_wr;
    logic [23:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        ack;
    logic [23:0] rdata;

    logic        o_stall, o_req, o_we;
    logic [23:0] o_addr, o_wdata;
    logic        o_valid;
    logic [23:0] o_pc, o_instr;
    logic        o_wb_en;
    logic [3:0]  o_tgt;
    logic [23:0] o_wb_data;
    logic        o_berr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stg4mo dut (
        .iw_clk       (clk),
        .iw_rst       (rst),
        .iw_valid     (valid),
        .iw_pc        (pc),
        .iw_instr     (instr),
        .iw_result    (result),
        .iw_wb_en     (wb_en),
        .iw_tgt_gp    (tgt),
        .iw_mem_rd    (mem_rd),
        .iw_mem_wr    (mem_wr),
        .iw_mem_addr  (mem_addr),
        .iw_mem_wdata (mem_wdata),
        .ow_stall     (o_stall),
        .ow_mem_req   (o_req),
        .ow_mem_we    (o_we),
        .ow_mem_addr  (o_addr),
        .ow_mem_wdata (o_wdata),
        .iw_mem_ack   (ack),
        .iw_mem_rdata (rdata),
        .ow_valid     (o_valid),
        .ow_pc        (o_pc),
        .ow_instr     (o_instr),
        .ow_wb_en     (o_wb_en),
        .ow_tgt_gp    (o_tgt),
        .ow_wb_data   (o_wb_data),
        .ow_bus_err   (o_berr)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        valid  = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic issue_load(input logic [23:0] a,
                              input logic [23:0] p);
        valid    = 1'b1;
        mem_rd   = 1'b1;
        mem_wr   = 1'b0;
        mem_addr = a;
        pc       = p;
        instr    = 24'h000003;
        tgt      = 4'd7;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        pc = '0; instr = '0; result = '0; wb_en = 1'b0;
        tgt = '0; mem_addr = '0; mem_wdata = '0;
        ack = 1'b0; rdata = '0;
        step(); step();
        check("rst_valid", o_valid, 0);
        check("rst_req", o_req, 0);
        check("rst_stall", o_stall, 0);
        check("rst_wbdata", o_wb_data, 0);
        check("rst_addr", o_addr, 0);
        rst = 1'b0;

        // ALU pass-through
        valid = 1'b1; pc = 24'h000010; instr = 24'h000013;
        result = 24'h00ABCD; wb_en = 1'b1; tgt = 4'd3;
        step();
        check("alu_valid", o_valid, 1);
        check("alu_data", o_wb_data, 24'h00ABCD);
        check("alu_tgt", o_tgt, 3);
        check("alu_pc", o_pc, 24'h000010);
        check("alu_wben", o_wb_en, 1);
        check("alu_stall", o_stall, 0);
        idle_in();
        step();
        check("alu_pulse", o_valid, 0);
        check("alu_hold", o_wb_data, 24'h00ABCD);

        // Load, ack in third WAIT cycle; idle ack ignored first
        ack = 1'b1; rdata = 24'h555555;
        step();
        check("idle_ack", o_valid, 0);
        ack = 1'b0;
        issue_load(24'h000100, 24'h000020);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check("ld_req", o_req, 1);
            check("ld_stall", o_stall, 1);
            check("ld_addr", o_addr, 24'h000100);
            check("ld_we", o_we, 0);
            check("ld_novalid", o_valid, 0);
            if (i == 2) begin
                ack = 1'b1; rdata = 24'h123456;
            end
            step();
        end
        ack = 1'b0;
        check("ld_valid", o_valid, 1);
        check("ld_wben", o_wb_en, 1);
        check("ld_data", o_wb_data, 24'h123456);
        check("ld_pc", o_pc, 24'h000020);
        check("ld_tgt", o_tgt, 7);
        check("ld_reqoff", o_req, 0);
        check("ld_stalloff", o_stall, 0);

        // Store, ALU op held under stall
        valid = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0;
        mem_addr = 24'h000200; mem_wdata = 24'h0000FF;
        pc = 24'h000030;
        step();
        check("st_req", o_req, 1);
        check("st_we", o_we, 1);
        check("st_wdata", o_wdata, 24'h0000FF);
        mem_wr = 1'b0; pc = 24'h000034;
        result = 24'h000777; wb_en = 1'b1; tgt = 4'd5;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("st_valid", o_valid, 1);
        check("st_wben", o_wb_en, 0);
        check("st_data", o_wb_data, 0);
        check("st_pc", o_pc, 24'h000030);
        check("st_stall", o_stall, 0);
        step();
        idle_in();
        check("b2b_valid", o_valid, 1);
        check("b2b_data", o_wb_data, 24'h000777);
        check("b2b_tgt", o_tgt, 5);
        check("b2b_pc", o_pc, 24'h000034);
        step();
        check("b2b_once", o_valid, 0);

        // Timeout, no ack
        issue_load(24'h000300, 24'h000040);
        step();
        idle_in();
        for (int i = 0; i < 15; i++) begin
            check("tmo_req", o_req, 1);
            check("tmo_noerr", o_berr, 0);
            step();
        end
        check("tmo_err", o_berr, 1);
        check("tmo_valid", o_valid, 1);
        check("tmo_wben", o_wb_en, 0);
        check("tmo_reqoff", o_req, 0);
        check("tmo_stall", o_stall, 0);
        step();
        check("tmo_errpulse", o_berr, 0);
        check("tmo_vpulse", o_valid, 0);

        // Ack coincides with final timeout cycle
        issue_load(24'h000400, 24'h000050);
        step();
        idle_in();
        for (int i = 0; i < 15; i++) begin
            check("race_req", o_req, 1);
            if (i == 14) begin
                ack = 1'b1; rdata = 24'hABC123;
            end
            step();
        end
        ack = 1'b0;
        check("race_valid", o_valid, 1);
        check("race_wben", o_wb_en, 1);
        check("race_err", o_berr, 0);
        check("race_data", o_wb_data, 24'hABC123);

        // Reset in second WAIT cycle
        issue_load(24'h000500, 24'h000060);
        step();
        idle_in();
        check("rw_req1", o_req, 1);
        step();
        check("rw_req2", o_req, 1);
        rst = 1'b1;
        step();
        check("rw_req", o_req, 0);
        check("rw_stall", o_stall, 0);
        check("rw_valid", o_valid, 0);
        check("rw_pc", o_pc, 0);
        check("rw_data", o_wb_data, 0);
        check("rw_addr", o_addr, 0);
        rst = 1'b0;
        ack = 1'b1; rdata = 24'h999999;
        step();
        ack = 1'b0;
        check("rw_lateack", o_valid, 0);
        check("rw_latedata", o_wb_data, 0);
        step();
        check("rw_idle", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
